// File: rtl/inst_fetch_pkg.sv
// Shared widths, PC helpers and FSM state encoding for the instruction-fetch front end.
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int PAIR_W = ADDR_W + INST_W;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

    typedef enum logic {
        WAKE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Redirect targets are word addresses; the low two bits are ignored.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ROM bus and IF/ID handshake bundle; master is the fetch unit, slave is ROM plus decode.
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              if_valid;
    logic              if_ready;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;

    modport master (
        output rom_ce, rom_addr, if_valid, if_pc, if_inst,
        input  rom_inst, if_ready
    );

    modport slave (
        input  rom_ce, rom_addr, if_valid, if_pc, if_inst,
        output rom_inst, if_ready
    );

endinterface

// File: rtl/inst_fetch_fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; clear beats push, push+pop allowed when full.
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    // The extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && (!full || pop) && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch front end: PC, WAKE/RUN FSM, redirects and prefetch FIFO feeding IF/ID.
// Define INST_FETCH_BYPASS_EN to forward ROM data straight to IF/ID when the FIFO is empty.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_pc,
    inst_fetch_if.master      bus
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [PAIR_W-1:0] last_pair;
    logic [PAIR_W-1:0] fifo_head;
    logic [PAIR_W-1:0] out_pair;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              pop;
    logic              push;
    logic              bypass;

    assign redirect    = flush || branch_flag;
    assign redirect_pc = align_pc(flush ? flush_pc : branch_pc);

`ifdef INST_FETCH_BYPASS_EN
    logic redirect_q;

    // An empty FIFO in RUN always fetches, so bypass need not look at push.
    assign bypass = fifo_empty && (state == RUN) && !redirect && !redirect_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) redirect_q <= 1'b0;
        else        redirect_q <= redirect;
    end
`else
    assign bypass = 1'b0;
`endif

    assign pop       = bus.if_valid && bus.if_ready;
    assign push      = (state == RUN) && (!fifo_full || pop);
    assign fifo_pop  = pop && !fifo_empty;
    assign fifo_push = push && !redirect && !(bypass && bus.if_ready);

    assign bus.rom_ce   = push;
    assign bus.rom_addr = (state == RUN) ? pc : '0;

    assign out_pair     = bypass     ? {pc, bus.rom_inst} :
                          fifo_empty ? last_pair : fifo_head;
    assign bus.if_valid = !fifo_empty || bypass;
    assign bus.if_pc    = out_pair[PAIR_W-1:INST_W];
    assign bus.if_inst  = out_pair[INST_W-1:0];

    fetch_fifo #(
        .DATA_W (PAIR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (redirect),
        .push_data ({pc, bus.rom_inst}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Redirects move the PC in either state; WAKE always falls through to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAKE;
            pc        <= RESET_PC;
            last_pair <= '0;
        end else begin
            case (state)
                WAKE:    state <= RUN;
                RUN:     state <= RUN;
                default: state <= WAKE;
            endcase
            if (redirect)  pc <= redirect_pc;
            else if (push) pc <= pc + PC_STEP;
            if (bus.if_valid) last_pair <= out_pair;
        end
    end

endmodule
